led_pattern_ctrl: RTL

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

---
 rtl/led_ctrl_pkg.sv | 20 ++
 rtl/led_tick_gen.sv | 27 ++
 rtl/led_pattern_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: opcodes, mode codes, FSM states and the LED step function
package led_ctrl_pkg;
  typedef enum logic [1:0] {S_OPC, S_DATA, S_APPLY} state_t;
  localparam logic [7:0] OP_MODE = 8'h01;
  localparam logic [7:0] OP_PERIOD = 8'h02;
  localparam logic [7:0] OP_PATTERN = 8'h03;
  localparam logic [2:0] M_STOP = 3'd0;
  localparam logic [2:0] M_RUN_R = 3'd1;
  localparam logic [2:0] M_RUN_L = 3'd2;
  localparam logic [2:0] M_BLINK = 3'd3;
  localparam logic [7:0] RST_PERIOD = 8'd199;
  function automatic logic valid_op(input logic [7:0] op);
    return op == OP_MODE || op == OP_PERIOD || op == OP_PATTERN;
  endfunction
  function automatic logic [7:0] next_led(input logic [2:0] m, input logic [7:0] l);
    return m == M_RUN_R ? {l[0], l[7:1]} :
           m == M_RUN_L ? {l[6:0], l[7]} :
           m == M_BLINK ? ~l : l;
  endfunction
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: 1 ms prescaler plus ms counter producing the pattern step tick
module led_tick_gen #(
  parameter int TICK_DIV = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [7:0] period,
  output logic       ms_tick,
  output logic       step_tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre;
  logic [7:0]    cnt;
  assign ms_tick = pre == PW'(TICK_DIV - 1);
  assign step_tick = ms_tick && cnt == period;
  // prescaler wraps at TICK_DIV-1; ms counter restarts on every step or clear
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= ms_tick ? '0 : pre + 1'b1;
      if (ms_tick) cnt <= step_tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: two-byte command parser driving a timed LED pattern engine
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 25000,
  parameter int TIMEOUT_MS = 255
) (
  input  logic       ext_clk_25m,
  input  logic       ext_rst,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] led,
  output logic [2:0] mode,
  output logic       step,
  output logic       cmd_err
);
  state_t      state, state_nx;
  logic [7:0]  opc, dat, period;
  logic [15:0] to_cnt;
  logic        rdy_en, ms_tick, step_tick, acc, timeout, bad_op, bad_mode, clr;
  assign cmd_ready = rdy_en && state != S_APPLY;
  assign acc = cmd_valid && cmd_ready;
  assign timeout = state == S_DATA && !acc && ms_tick && to_cnt == 16'(TIMEOUT_MS - 1);
  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk      (ext_clk_25m),
    .rst      (ext_rst),
    .clr      (clr),
    .period   (period),
    .ms_tick  (ms_tick),
    .step_tick(step_tick)
  );
  // state register
  always_ff @(posedge ext_clk_25m) begin
    if (ext_rst) state <= S_OPC;
    else state <= state_nx;
  end
  // next state plus opcode/mode error and tick-clear decode
  always_comb begin
    state_nx = state;
    bad_op = 1'b0;
    bad_mode = 1'b0;
    clr = 1'b0;
    if (state == S_OPC && acc) begin
      bad_op = !valid_op(cmd_data);
      state_nx = bad_op ? S_OPC : S_DATA;
    end else if (state == S_DATA && acc) begin
      state_nx = S_APPLY;
    end else if (timeout) begin
      state_nx = S_OPC;
    end else if (state == S_APPLY) begin
      state_nx = S_OPC;
      bad_mode = opc == OP_MODE && dat[2:0] > M_BLINK;
      clr = (opc == OP_MODE && !bad_mode) || opc == OP_PERIOD;
    end
  end
  // command capture, pattern registers and registered pulses; apply beats a coincident step
  always_ff @(posedge ext_clk_25m) begin
    if (ext_rst) begin
      led <= 8'h01;
      mode <= M_RUN_R;
      period <= RST_PERIOD;
      opc <= '0;
      dat <= '0;
      to_cnt <= '0;
      rdy_en <= 1'b0;
      step <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      step <= step_tick && state != S_APPLY;
      cmd_err <= bad_op || bad_mode || timeout;
      to_cnt <= state != S_DATA ? '0 : to_cnt + 16'(ms_tick);
      if (state == S_OPC && acc) opc <= cmd_data;
      if (state == S_DATA && acc) dat <= cmd_data;
      if (state == S_APPLY) begin
        if (opc == OP_MODE && !bad_mode) mode <= dat[2:0];
        if (opc == OP_PERIOD) period <= dat;
        if (opc == OP_PATTERN) led <= dat;
      end else if (step_tick) begin
        led <= next_led(mode, led);
      end
    end
  end
endmodule
